// File: rtl/leaf_port_pkg.sv
// -----------------------------------------------------------------------------
// leaf_port_pkg
// Shared types and constants for the leaf port bank:
//   - seq_state_t   : start sequencer state (IDLE/LOAD/ARMED/RUN), 2 bits
//   - STATE_BITS    : width of the sequencer state / state_out port
//   - STAT_CNT_BITS : width of each per-channel transfer counter
// -----------------------------------------------------------------------------
package leaf_port_pkg;

    localparam int STATE_BITS    = 2;
    localparam int STAT_CNT_BITS = 16;

    typedef enum logic [STATE_BITS-1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ARMED = 2'd2,
        ST_RUN   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/leaf_port_fifo.sv
// -----------------------------------------------------------------------------
// leaf_port_fifo
// Single-clock FIFO with valid/ack handshakes on both sides and a synchronous
// flush. The head word is presented combinationally, so a word written on
// edge N is visible (o_rd_vld=1) right after edge N.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_flush               synchronous clear of pointers and count
//   i_wr_data/i_wr_vld    write side word and valid
//   o_wr_ack              write side ack, high while not full
//   o_rd_data/o_rd_vld    head word (0 when empty) and not-empty flag
//   i_rd_ack              read side pop request
// -----------------------------------------------------------------------------
module leaf_port_fifo #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_wr_vld,
    output logic             o_wr_ack,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_rd_vld,
    input  logic             i_rd_ack
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] FULL_COUNT = {1'b1, {ADDR_BITS{1'b0}}};

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [ADDR_BITS-1:0] r_wr_ptr;
    logic [ADDR_BITS-1:0] r_rd_ptr;
    logic [ADDR_BITS:0]   r_count;
    logic                 w_push;
    logic                 w_pop;

    // Ack depends on the count alone: a full FIFO refuses a word even if the
    // head is popped in the same cycle.
    assign o_wr_ack  = (r_count != FULL_COUNT);
    assign o_rd_vld  = (r_count != '0);
    assign w_push    = i_wr_vld & o_wr_ack;
    assign w_pop     = i_rd_ack & o_rd_vld;
    assign o_rd_data = o_rd_vld ? r_mem[r_rd_ptr] : '0;

    // Storage carries no reset; the output mux hides stale contents.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/leaf_port_bank.sv
// -----------------------------------------------------------------------------
// leaf_port_bank
// Buffering and sequencing shell between leaf_interface and a user core.
//   - NUM_IN_PORTS interface->user FIFOs and NUM_OUT_PORTS user->interface FIFOs
//   - one register stage on the instruction config write path
//   - start sequencer driving the core's active-low reset
// Ports:
//   clk_user, resetn                      clock, asynchronous active-low reset
//   ap_start                              level start request
//   if_din/if_vld_in/if_ack_in            interface -> in-FIFOs
//   user_dout/user_vld_out/user_ack_out   in-FIFO heads -> core
//   user_din/user_vld_in/user_ack_in      core -> out-FIFOs
//   if_dout/if_vld_out/if_ack_out         out-FIFO heads -> interface
//   cfg_*_in / cfg_*_out                  config write, registered to the core
//   core_resetn                           core reset, high only in RUN
//   cfg_err                               sticky: config write while ARMED/RUN
//   state_out                             sequencer state
//   stat_xfer_cnt                         per-channel 16-bit saturating
//                                         transfer counters, in-channels
//                                         first (only with LEAF_PORT_STATS_EN)
// Build option: define LEAF_PORT_STATS_EN to add stat_xfer_cnt.
// -----------------------------------------------------------------------------
module leaf_port_bank
    import leaf_port_pkg::*;
#(
    parameter int PAYLOAD_BITS   = 32,
    parameter int NUM_IN_PORTS   = 5,
    parameter int NUM_OUT_PORTS  = 5,
    parameter int FIFO_ADDR_BITS = 2,
    parameter int CFG_ADDR_BITS  = 24,
    parameter int CFG_DATA_BITS  = 8,
    parameter int START_DELAY    = 4
) (
    input  logic                                    clk_user,
    input  logic                                    resetn,
    input  logic                                    ap_start,
    input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    if_din,
    input  logic [NUM_IN_PORTS-1:0]                 if_vld_in,
    output logic [NUM_IN_PORTS-1:0]                 if_ack_in,
    output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    user_dout,
    output logic [NUM_IN_PORTS-1:0]                 user_vld_out,
    input  logic [NUM_IN_PORTS-1:0]                 user_ack_out,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   user_din,
    input  logic [NUM_OUT_PORTS-1:0]                user_vld_in,
    output logic [NUM_OUT_PORTS-1:0]                user_ack_in,
    output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   if_dout,
    output logic [NUM_OUT_PORTS-1:0]                if_vld_out,
    input  logic [NUM_OUT_PORTS-1:0]                if_ack_out,
    input  logic [CFG_ADDR_BITS-1:0]                cfg_addr_in,
    input  logic [CFG_DATA_BITS-1:0]                cfg_data_in,
    input  logic                                    cfg_wr_en_in,
    output logic [CFG_ADDR_BITS-1:0]                cfg_addr_out,
    output logic [CFG_DATA_BITS-1:0]                cfg_data_out,
    output logic                                    cfg_wr_en_out,
    output logic                                    core_resetn,
    output logic                                    cfg_err,
    output logic [STATE_BITS-1:0]                   state_out
`ifdef LEAF_PORT_STATS_EN
    ,
    output logic [(NUM_IN_PORTS+NUM_OUT_PORTS)*STAT_CNT_BITS-1:0] stat_xfer_cnt
`endif
);

    localparam logic [7:0] DELAY_LAST = 8'(START_DELAY - 1);

    seq_state_t             r_state;
    seq_state_t             w_state_next;
    logic [7:0]             r_delay_cnt;
    logic                   w_armed_done;
    logic                   w_flush;
    logic                   w_cfg_accept;
    logic                   w_cfg_reject;
    logic                   w_core_run_next;

    logic                   r_core_resetn;
    logic                   r_cfg_err;
    logic                   r_cfg_wr_en;
    logic [CFG_ADDR_BITS-1:0] r_cfg_addr;
    logic [CFG_DATA_BITS-1:0] r_cfg_data;

    // ---------------- sequencer: state register ----------------
    always_ff @(posedge clk_user or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Cycles spent in ARMED; restarts from 0 on every entry.
    always_ff @(posedge clk_user or negedge resetn) begin
        if (!resetn) begin
            r_delay_cnt <= '0;
        end else if (r_state == ST_ARMED) begin
            r_delay_cnt <= r_delay_cnt + 8'd1;
        end else begin
            r_delay_cnt <= '0;
        end
    end

    assign w_armed_done = (r_delay_cnt == DELAY_LAST);

    // ---------------- sequencer: next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (ap_start) begin
                    w_state_next = ST_ARMED;
                end else if (cfg_wr_en_in) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ap_start) begin
                    w_state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!ap_start) begin
                    w_state_next = ST_IDLE;
                end else if (w_armed_done) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!ap_start) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- sequencer: output decode ----------------
    always_comb begin
        w_flush         = (r_state == ST_RUN) && !ap_start;
        w_cfg_accept    = cfg_wr_en_in && ((r_state == ST_IDLE) || (r_state == ST_LOAD));
        w_cfg_reject    = cfg_wr_en_in && ((r_state == ST_ARMED) || (r_state == ST_RUN));
        w_core_run_next = (w_state_next == ST_RUN);
    end

    // core_resetn comes straight from a flop, so it rises on the edge that
    // enters RUN and falls on the edge that leaves it, without glitches.
    always_ff @(posedge clk_user or negedge resetn) begin
        if (!resetn) begin
            r_core_resetn <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_cfg_wr_en   <= 1'b0;
            r_cfg_addr    <= '0;
            r_cfg_data    <= '0;
        end else begin
            r_core_resetn <= w_core_run_next;
            r_cfg_err     <= r_cfg_err | w_cfg_reject;
            r_cfg_wr_en   <= w_cfg_accept;
            if (w_cfg_accept) begin
                r_cfg_addr <= cfg_addr_in;
                r_cfg_data <= cfg_data_in;
            end
        end
    end

    assign core_resetn   = r_core_resetn;
    assign cfg_err       = r_cfg_err;
    assign cfg_wr_en_out = r_cfg_wr_en;
    assign cfg_addr_out  = r_cfg_addr;
    assign cfg_data_out  = r_cfg_data;
    assign state_out     = r_state;

    // ---------------- channel FIFOs ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN_PORTS; gi++) begin : g_in
            leaf_port_fifo #(
                .WIDTH     (PAYLOAD_BITS),
                .ADDR_BITS (FIFO_ADDR_BITS)
            ) u_fifo (
                .i_clk     (clk_user),
                .i_rst_n   (resetn),
                .i_flush   (w_flush),
                .i_wr_data (if_din[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
                .i_wr_vld  (if_vld_in[gi]),
                .o_wr_ack  (if_ack_in[gi]),
                .o_rd_data (user_dout[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
                .o_rd_vld  (user_vld_out[gi]),
                .i_rd_ack  (user_ack_out[gi])
            );
        end

        for (gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_out
            leaf_port_fifo #(
                .WIDTH     (PAYLOAD_BITS),
                .ADDR_BITS (FIFO_ADDR_BITS)
            ) u_fifo (
                .i_clk     (clk_user),
                .i_rst_n   (resetn),
                .i_flush   (w_flush),
                .i_wr_data (user_din[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
                .i_wr_vld  (user_vld_in[gi]),
                .o_wr_ack  (user_ack_in[gi]),
                .o_rd_data (if_dout[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
                .o_rd_vld  (if_vld_out[gi]),
                .i_rd_ack  (if_ack_out[gi])
            );
        end
    endgenerate

`ifdef LEAF_PORT_STATS_EN
    // ---------------- per-channel transfer counters ----------------
    localparam int NUM_CH = NUM_IN_PORTS + NUM_OUT_PORTS;

    // A transfer is counted on the FIFO write side of each channel.
    logic [NUM_CH-1:0] w_xfer;
    assign w_xfer = {user_vld_in & user_ack_in, if_vld_in & if_ack_in};

    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_stat
            logic [STAT_CNT_BITS-1:0] r_cnt;

            always_ff @(posedge clk_user or negedge resetn) begin
                if (!resetn) begin
                    r_cnt <= '0;
                end else if (w_flush) begin
                    r_cnt <= '0;
                end else if ((r_state == ST_RUN) && w_xfer[gi] && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign stat_xfer_cnt[gi*STAT_CNT_BITS +: STAT_CNT_BITS] = r_cnt;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_leaf_port_bank.sv
`timescale 1ns/1ps
module tb_leaf_port_bank;

    localparam int PW    = 32;
    localparam int NI    = 5;
    localparam int NO    = 5;
    localparam int FAB   = 2;
    localparam int DEPTH = 4;
    localparam int CAB   = 24;
    localparam int CDB   = 8;
    localparam int SD    = 4;

    logic              clk_user = 1'b0;
    logic              resetn   = 1'b0;
    logic              ap_start = 1'b0;
    logic [NI*PW-1:0]  if_din = '0;
    logic [NI-1:0]     if_vld_in = '0;
    logic [NI-1:0]     if_ack_in;
    logic [NI*PW-1:0]  user_dout;
    logic [NI-1:0]     user_vld_out;
    logic [NI-1:0]     user_ack_out = '0;
    logic [NO*PW-1:0]  user_din = '0;
    logic [NO-1:0]     user_vld_in = '0;
    logic [NO-1:0]     user_ack_in;
    logic [NO*PW-1:0]  if_dout;
    logic [NO-1:0]     if_vld_out;
    logic [NO-1:0]     if_ack_out = '0;
    logic [CAB-1:0]    cfg_addr_in = '0;
    logic [CDB-1:0]    cfg_data_in = '0;
    logic              cfg_wr_en_in = 1'b0;
    logic [CAB-1:0]    cfg_addr_out;
    logic [CDB-1:0]    cfg_data_out;
    logic              cfg_wr_en_out;
    logic              core_resetn;
    logic              cfg_err;
    logic [1:0]        state_out;
`ifdef LEAF_PORT_STATS_EN
    logic [(NI+NO)*16-1:0] stat_xfer_cnt;
`endif

    leaf_port_bank #(
        .PAYLOAD_BITS(PW), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO),
        .FIFO_ADDR_BITS(FAB), .CFG_ADDR_BITS(CAB), .CFG_DATA_BITS(CDB),
        .START_DELAY(SD)
    ) dut (
        .clk_user(clk_user), .resetn(resetn), .ap_start(ap_start),
        .if_din(if_din), .if_vld_in(if_vld_in), .if_ack_in(if_ack_in),
        .user_dout(user_dout), .user_vld_out(user_vld_out), .user_ack_out(user_ack_out),
        .user_din(user_din), .user_vld_in(user_vld_in), .user_ack_in(user_ack_in),
        .if_dout(if_dout), .if_vld_out(if_vld_out), .if_ack_out(if_ack_out),
        .cfg_addr_in(cfg_addr_in), .cfg_data_in(cfg_data_in), .cfg_wr_en_in(cfg_wr_en_in),
        .cfg_addr_out(cfg_addr_out), .cfg_data_out(cfg_data_out), .cfg_wr_en_out(cfg_wr_en_out),
        .core_resetn(core_resetn), .cfg_err(cfg_err), .state_out(state_out)
`ifdef LEAF_PORT_STATS_EN
        , .stat_xfer_cnt(stat_xfer_cnt)
`endif
    );

    always #5 clk_user = ~clk_user;

    int errors = 0;
    int checks = 0;

    // Reference model: one queue per channel plus an abstract sequencer.
    logic [PW-1:0]  mq_in  [NI][$];
    logic [PW-1:0]  mq_out [NO][$];
    int             m_state;       // 0 idle, 1 load, 2 armed, 3 run
    int             m_armed;       // edges seen while armed
    bit [NI-1:0]    last_in_push;
    bit [NO-1:0]    last_out_push;

    task automatic model_reset();
        for (int i = 0; i < NI; i++) mq_in[i].delete();
        for (int i = 0; i < NO; i++) mq_out[i].delete();
        m_state = 0;
        m_armed = 0;
        last_in_push = '0;
        last_out_push = '0;
    endtask

    // One clock edge; the model advances with the inputs present at the edge.
    task automatic step();
        bit          flush;
        bit [NI-1:0] ipush, ipop;
        bit [NO-1:0] opush, opop;
        int          nst;
        flush = (m_state == 3) && !ap_start;
        for (int i = 0; i < NI; i++) begin
            ipush[i] = if_vld_in[i] && (mq_in[i].size() < DEPTH);
            ipop[i]  = user_ack_out[i] && (mq_in[i].size() > 0);
        end
        for (int i = 0; i < NO; i++) begin
            opush[i] = user_vld_in[i] && (mq_out[i].size() < DEPTH);
            opop[i]  = if_ack_out[i] && (mq_out[i].size() > 0);
        end
        nst = m_state;
        case (m_state)
            0: if (ap_start) begin nst = 2; m_armed = 0; end
               else if (cfg_wr_en_in) nst = 1;
            1: if (ap_start) begin nst = 2; m_armed = 0; end
            2: if (!ap_start) nst = 0;
               else begin m_armed++; if (m_armed == SD) nst = 3; end
            3: if (!ap_start) nst = 0;
            default: nst = 0;
        endcase
        @(posedge clk_user);
        for (int i = 0; i < NI; i++) begin
            if (flush) mq_in[i].delete();
            else begin
                if (ipop[i]) void'(mq_in[i].pop_front());
                if (ipush[i]) mq_in[i].push_back(if_din[i*PW +: PW]);
            end
        end
        for (int i = 0; i < NO; i++) begin
            if (flush) mq_out[i].delete();
            else begin
                if (opop[i]) void'(mq_out[i].pop_front());
                if (opush[i]) mq_out[i].push_back(user_din[i*PW +: PW]);
            end
        end
        last_in_push  = ipush;
        last_out_push = opush;
        m_state = nst;
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_user);
        #1;
        checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_out); end
        checks++; if (core_resetn !== 1'b0) begin errors++; $display("FAIL reset_core_resetn: got %b want 0", core_resetn); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
        checks++; if ({cfg_wr_en_out, cfg_addr_out, cfg_data_out} !== '0) begin errors++; $display("FAIL reset_cfg_out: got %b/%h/%h want 0", cfg_wr_en_out, cfg_addr_out, cfg_data_out); end
        checks++; if ({user_vld_out, if_vld_out} !== '0) begin errors++; $display("FAIL reset_vld: got %b %b want 0", user_vld_out, if_vld_out); end
        checks++; if ({user_dout, if_dout} !== '0) begin errors++; $display("FAIL reset_data: got nonzero data, want 0"); end
        resetn = 1'b1;
        step();
        checks++; if (if_ack_in !== '1) begin errors++; $display("FAIL reset_if_ack_in: got %b want all 1", if_ack_in); end
        checks++; if (user_ack_in !== '1) begin errors++; $display("FAIL reset_user_ack_in: got %b want all 1", user_ack_in); end
        $display("test_reset done: errors=%0d", errors);
    endtask

    task automatic test_in_fill();
        checks++; if (user_vld_out[2] !== 1'b0) begin errors++; $display("FAIL fill_pre_vld: got %b want 0", user_vld_out[2]); end
        for (int k = 0; k < 5; k++) begin
            if_din[2*PW +: PW] = 32'hA5A5_0001 + k;
            if_vld_in[2] = 1'b1;
            step();
            checks++; if (user_vld_out[2] !== 1'b1) begin errors++; $display("FAIL fill_vld[%0d]: got %b want 1", k, user_vld_out[2]); end
            checks++; if (user_dout[2*PW +: PW] !== 32'hA5A5_0001) begin errors++; $display("FAIL fill_head[%0d]: got %h want a5a50001", k, user_dout[2*PW +: PW]); end
            checks++; if (if_ack_in[2] !== (k + 1 < DEPTH)) begin errors++; $display("FAIL fill_ack[%0d]: got %b want %b", k, if_ack_in[2], (k + 1 < DEPTH)); end
            $display("push ch2 word %h ack_after=%b", 32'hA5A5_0001 + k, if_ack_in[2]);
        end
        if_vld_in[2] = 1'b0;
        user_ack_out[2] = 1'b1;
        for (int j = 0; j < DEPTH; j++) begin
            checks++; if (user_dout[2*PW +: PW] !== 32'hA5A5_0001 + j) begin errors++; $display("FAIL drain_head[%0d]: got %h want %h", j, user_dout[2*PW +: PW], 32'hA5A5_0001 + j); end
            step();
        end
        checks++; if (user_vld_out[2] !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0 (fifth word must be dropped)", user_vld_out[2]); end
        user_ack_out[2] = 1'b0;
        $display("test_in_fill done: errors=%0d", errors);
    endtask

    task automatic test_out_stream();
        int p = 0;
        int n = 0;
        logic [PW-1:0] base = 32'h0C00_0000;
        user_vld_in[0] = 1'b1;
        repeat (2) begin user_din[0 +: PW] = base + n; n++; step(); end
        for (int c = 0; c < 10; c++) begin
            checks++; if (if_vld_out[0] !== 1'b1 || user_ack_in[0] !== 1'b1) begin errors++; $display("FAIL stream_flags[%0d]: got vld=%b ack=%b want 1/1", c, if_vld_out[0], user_ack_in[0]); end
            checks++; if (if_dout[0 +: PW] !== base + p) begin errors++; $display("FAIL stream_head[%0d]: got %h want %h", c, if_dout[0 +: PW], base + p); end
            user_din[0 +: PW] = base + n;
            if_ack_out[0] = 1'b1;
            step();
            $display("stream out0 push %h pop %h", base + n, base + p);
            p++; n++;
        end
        user_vld_in[0] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++; if (if_dout[0 +: PW] !== base + p) begin errors++; $display("FAIL stream_tail[%0d]: got %h want %h", c, if_dout[0 +: PW], base + p); end
            step();
            p++;
        end
        checks++; if (if_vld_out[0] !== 1'b0) begin errors++; $display("FAIL stream_empty: got %b want 0", if_vld_out[0]); end
        if_ack_out[0] = 1'b0;
        $display("test_out_stream done: errors=%0d", errors);
    endtask

    task automatic test_config();
        cfg_addr_in = 24'h000010;
        cfg_data_in = 8'h13;
        cfg_wr_en_in = 1'b1;
        step();
        cfg_wr_en_in = 1'b0;
        checks++; if (cfg_wr_en_out !== 1'b1) begin errors++; $display("FAIL cfg_strobe: got %b want 1", cfg_wr_en_out); end
        checks++; if (cfg_addr_out !== 24'h000010 || cfg_data_out !== 8'h13) begin errors++; $display("FAIL cfg_word: got %h/%h want 000010/13", cfg_addr_out, cfg_data_out); end
        checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL cfg_state: got %0d want 1", state_out); end
        step();
        checks++; if (cfg_wr_en_out !== 1'b0) begin errors++; $display("FAIL cfg_strobe_len: got %b want 0", cfg_wr_en_out); end
        $display("cfg write addr 000010 data 13 state=%0d", state_out);
    endtask

    task automatic test_sequencer();
        ap_start = 1'b1;
        for (int k = 1; k <= SD + 1; k++) begin
            step();
            checks++; if (state_out !== ((k <= SD) ? 2'd2 : 2'd3)) begin errors++; $display("FAIL seq_state[%0d]: got %0d want %0d", k, state_out, (k <= SD) ? 2 : 3); end
            checks++; if (core_resetn !== (k == SD + 1)) begin errors++; $display("FAIL seq_core_resetn[%0d]: got %b want %b", k, core_resetn, (k == SD + 1)); end
        end
        cfg_addr_in = 24'h000020;
        cfg_data_in = 8'h77;
        cfg_wr_en_in = 1'b1;
        step();
        cfg_wr_en_in = 1'b0;
        checks++; if (cfg_wr_en_out !== 1'b0) begin errors++; $display("FAIL run_cfg_strobe: got %b want 0", cfg_wr_en_out); end
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL run_cfg_err: got %b want 1", cfg_err); end
        checks++; if (cfg_addr_out !== 24'h000010) begin errors++; $display("FAIL run_cfg_addr: got %h want 000010", cfg_addr_out); end
        checks++; if (state_out !== 2'd3 || core_resetn !== 1'b1) begin errors++; $display("FAIL run_hold: got state %0d core %b want 3/1", state_out, core_resetn); end
        $display("test_sequencer done: errors=%0d", errors);
    endtask

    task automatic test_flush();
        user_ack_out = '0;
        if_ack_out = '0;
        for (int k = 0; k < 3; k++) begin
            if_din[1*PW +: PW] = 32'h1100_0000 + k; if_vld_in[1] = 1'b1;
            user_din[3*PW +: PW] = 32'h3300_0000 + k; user_vld_in[3] = 1'b1;
            step();
        end
        if_vld_in = '0;
        user_vld_in = '0;
        checks++; if (user_vld_out[1] !== 1'b1 || if_vld_out[3] !== 1'b1) begin errors++; $display("FAIL flush_pre: got %b/%b want 1/1", user_vld_out[1], if_vld_out[3]); end
        ap_start = 1'b0;
        step();
        checks++; if (core_resetn !== 1'b0) begin errors++; $display("FAIL flush_core_resetn: got %b want 0", core_resetn); end
        checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL flush_state: got %0d want 0", state_out); end
        checks++; if ({user_vld_out, if_vld_out} !== '0) begin errors++; $display("FAIL flush_vld: got %b %b want 0", user_vld_out, if_vld_out); end
        checks++; if (if_ack_in !== '1 || user_ack_in !== '1) begin errors++; $display("FAIL flush_ack: got %b %b want all 1", if_ack_in, user_ack_in); end
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL flush_cfg_err_sticky: got %b want 1", cfg_err); end
        $display("test_flush done: errors=%0d", errors);
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NI; i++) begin
                if (!(if_vld_in[i] && !last_in_push[i])) begin
                    if_vld_in[i] = ($urandom_range(0, 99) < 60);
                    if_din[i*PW +: PW] = $urandom;
                end
                user_ack_out[i] = ($urandom_range(0, 99) < 45);
            end
            for (int i = 0; i < NO; i++) begin
                if (!(user_vld_in[i] && !last_out_push[i])) begin
                    user_vld_in[i] = ($urandom_range(0, 99) < 55);
                    user_din[i*PW +: PW] = $urandom;
                end
                if_ack_out[i] = ($urandom_range(0, 99) < 50);
            end
            step();
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (user_vld_out[i] !== (mq_in[i].size() != 0) || if_ack_in[i] !== (mq_in[i].size() != DEPTH)) begin
                    errors++; $display("FAIL rand_in_flags ch%0d cyc%0d: got vld=%b ack=%b want count %0d", i, c, user_vld_out[i], if_ack_in[i], mq_in[i].size());
                end else if (mq_in[i].size() != 0 && user_dout[i*PW +: PW] !== mq_in[i][0]) begin
                    errors++; $display("FAIL rand_in_head ch%0d cyc%0d: got %h want %h", i, c, user_dout[i*PW +: PW], mq_in[i][0]);
                end
            end
            for (int i = 0; i < NO; i++) begin
                checks++;
                if (if_vld_out[i] !== (mq_out[i].size() != 0) || user_ack_in[i] !== (mq_out[i].size() != DEPTH)) begin
                    errors++; $display("FAIL rand_out_flags ch%0d cyc%0d: got vld=%b ack=%b want count %0d", i, c, if_vld_out[i], user_ack_in[i], mq_out[i].size());
                end else if (mq_out[i].size() != 0 && if_dout[i*PW +: PW] !== mq_out[i][0]) begin
                    errors++; $display("FAIL rand_out_head ch%0d cyc%0d: got %h want %h", i, c, if_dout[i*PW +: PW], mq_out[i][0]);
                end
            end
        end
        if_vld_in = '0; user_vld_in = '0; user_ack_out = '1; if_ack_out = '1;
        repeat (DEPTH) step();
        user_ack_out = '0; if_ack_out = '0;
        checks++; if ({user_vld_out, if_vld_out} !== '0) begin errors++; $display("FAIL rand_drain: got %b %b want 0", user_vld_out, if_vld_out); end
        $display("test_random done: errors=%0d", errors);
    endtask

    task automatic test_armed_abort();
        ap_start = 1'b1;
        step();
        checks++; if (state_out !== 2'd2 || core_resetn !== 1'b0) begin errors++; $display("FAIL abort_armed: got state %0d core %b want 2/0", state_out, core_resetn); end
        ap_start = 1'b0;
        step();
        checks++; if (state_out !== 2'd0 || core_resetn !== 1'b0) begin errors++; $display("FAIL abort_idle: got state %0d core %b want 0/0", state_out, core_resetn); end
        $display("test_armed_abort done: errors=%0d", errors);
    endtask

    task automatic test_async_reset();
        ap_start = 1'b1;
        repeat (SD + 1) step();
        checks++; if (state_out !== 2'd3 || core_resetn !== 1'b1) begin errors++; $display("FAIL arst_setup: got state %0d core %b want 3/1", state_out, core_resetn); end
        if_din[0 +: PW] = 32'hDEAD_0000; if_vld_in[0] = 1'b1;
        step(); step();
        if_vld_in[0] = 1'b0;
        @(posedge clk_user);
        #3 resetn = 1'b0;
        ap_start = 1'b0;
        #1;
        checks++; if (state_out !== 2'd0 || core_resetn !== 1'b0) begin errors++; $display("FAIL arst_state: got state %0d core %b want 0/0", state_out, core_resetn); end
        checks++; if (cfg_err !== 1'b0 || {cfg_wr_en_out, cfg_addr_out, cfg_data_out} !== '0) begin errors++; $display("FAIL arst_cfg: got err %b cfg %h/%h want 0", cfg_err, cfg_addr_out, cfg_data_out); end
        checks++; if ({user_vld_out, if_vld_out} !== '0 || user_dout !== '0) begin errors++; $display("FAIL arst_fifo: got vld %b %b want 0", user_vld_out, if_vld_out); end
        checks++; if (if_ack_in !== '1 || user_ack_in !== '1) begin errors++; $display("FAIL arst_ack: got %b %b want all 1", if_ack_in, user_ack_in); end
        model_reset();
        repeat (2) @(posedge clk_user);
        #1 resetn = 1'b1;
        step();
        checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL arst_release: got %0d want 0", state_out); end
        $display("test_async_reset done: errors=%0d", errors);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_in_fill();
        test_out_stream();
        test_config();
        test_sequencer();
        test_flush();
        test_random();
        test_armed_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
